d_sink_counter: RTL and testbench
=================================

# d_sink_counter

Downstream sink stage for the PCIe QoS interconnect. It drains the two destination FIFOs (D0, D1) with round-robin pops and forwards each popped word. It keeps a saturating word count per {destination, virtual channel} class. Counts are readable through a request/valid handshake that is honoured only while the condition FSM reports idle.

## Interface
Parameters:
- BW, 6, word width; must match the interconnect's BW. Bit BW-1 of a word is its vc_id.
- CW, 5, counter width. Counters saturate at 2^CW-1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_L  input  1  reset, asynchronous, active-low.
- pop_en  input  1  enables popping of D0/D1.
- D0_empty  input  1  D0 FIFO empty flag.
- D1_empty  input  1  D1 FIFO empty flag.
- D0_data_out  input  BW  D0 read data; valid the cycle after D0_rd.
- D1_data_out  input  BW  D1 read data; valid the cycle after D1_rd.
- idle  input  1  idle_out_cond from the condition FSM.
- req  input  1  count read request.
- idx  input  2  requested class: idx[1] = destination (0=D0, 1=D1), idx[0] = vc_id.
- D0_rd  output  1  pop D0 (combinational).
- D1_rd  output  1  pop D1 (combinational).
- out_data  output  BW  forwarded word (registered).
- out_dest  output  1  destination of out_data (registered).
- out_valid  output  1  out_data valid this cycle (registered).
- data  output  CW  count read-back (registered).
- valid  output  1  data valid this cycle (registered).

## Operation
- **Reset.** While reset_L=0, all registers clear asynchronously and D0_rd/D1_rd are forced to 0. Registered outputs reset to: out_data=0, out_dest=0, out_valid=0, data=0, valid=0. The four counters clear to 0 and last_grant resets to D1, so D0 wins the first tie.
- **Arbiter.** Runs only when reset_L=1 and pop_en=1. At most one of D0_rd/D1_rd is 1 in any cycle.
  - Only D0 non-empty: D0_rd=1.
  - Only D1 non-empty: D1_rd=1.
  - Both non-empty: grant the FIFO that is not last_grant.
  - Neither non-empty, or pop_en=0: no pop.
  - last_grant updates on every grant.
- **Capture pipeline.** The granted FIFO is registered as pend_valid/pend_src.
  - On the following edge, the word from the selected data_out is latched into out_data, out_dest=pend_src and out_valid=1. Otherwise out_valid=0.
  - The same edge increments counter[{pend_src, word[BW-1]}] by 1, saturating at 2^CW-1 (no wrap).
- **In-flight pop.** Dropping pop_en after a grant stops new pops only. The in-flight word is still captured and counted.
- **Read-back.** req is sampled each edge.
  - req=1 and idle=1: the next cycle has valid=1 and data=counter[idx]. data is the counter value before any increment on that same edge.
  - req=0 or idle=0: valid=0 and data holds its previous value.
  - req held high gives one response per cycle.
- **Counter clearing.** Counters are never cleared by a read; only reset clears them.
- **Simultaneous events.** A capture increment and a read of the same class on one edge return the old value; the new value is visible from the next request.
- **Mid-operation reset.** A reset asserted mid-operation discards any pending pop. After release, the first pop needs a fresh grant.

## Timing
- D0_rd/D1_rd: combinational from D0_empty, D1_empty, pop_en and last_grant. No registered delay.
- Grant at edge N → out_valid=1 and count updated after edge N+1 (1-cycle capture latency). Sustained throughput is 1 word/cycle.
- req at edge N → valid/data after edge N, for exactly one cycle per sampled request.
- Sustained throughput covers both FIFOs interleaved D0, D1, D0, ... when both stay non-empty.

## Test plan
- **Reset values.** Assert reset_L=0 mid-stream with D0 non-empty and pop_en=1 → D0_rd=0 immediately and all outputs 0. After release, the first tie goes to D0.
- **Round-robin.** Both FIFOs non-empty for 6 cycles → rd pattern D0,D1,D0,D1,D0,D1. Each out_valid appears one cycle after its rd, with out_dest matching.
- **Class counting.** Pop D0 words with vc_id 0,1,1 and a D1 word with vc_id 0; then idle=1 and req with idx=0,1,2,3 → data=1,2,1,0.
- **Saturation.** Pop 40 D1 words with vc_id=1, then request idx=3 → data=31 (no wrap to 8).
- **Idle gating.** req=1 with idle=0 → valid=0 and data unchanged. Raise idle=1 → valid=1 the next cycle.
- **pop_en drop and coincident read.** Drop pop_en the cycle after a D0 grant → the in-flight word is still output and counted, and no further rd. A read of the same class on the capture edge returns the pre-increment count.

Source files
------------

// File: rtl/d_sink_counter.sv
// Sink stage: round-robin drain of the D0/D1 FIFOs, one-cycle capture of the popped
// word, and saturating per-{destination, vc} word counters with idle-gated read-back.
module d_sink_counter #(
    parameter int BW = 6,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          pop_en,
    input  logic          D0_empty,
    input  logic          D1_empty,
    input  logic [BW-1:0] D0_data_out,
    input  logic [BW-1:0] D1_data_out,
    input  logic          idle,
    input  logic          req,
    input  logic [1:0]    idx,
    output logic          D0_rd,
    output logic          D1_rd,
    output logic [BW-1:0] out_data,
    output logic          out_dest,
    output logic          out_valid,
    output logic [CW-1:0] data,
    output logic          valid
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    // last_grant: 0 = D0, 1 = D1. Resets to D1 so D0 wins the first tie.
    logic          last_grant;
    logic          pend_valid;
    logic          pend_src;
    logic [BW-1:0] cap_word;
    logic [1:0]    cap_class;
    logic [CW-1:0] cnt [4];

    always_comb begin
        D0_rd = 1'b0;
        D1_rd = 1'b0;
        if (reset_L && pop_en) begin
            if (!D0_empty && !D1_empty) begin
                if (last_grant) D0_rd = 1'b1;
                else            D1_rd = 1'b1;
            end else if (!D0_empty) begin
                D0_rd = 1'b1;
            end else if (!D1_empty) begin
                D1_rd = 1'b1;
            end
        end
    end

    // The popped FIFO presents its word one cycle after rd, i.e. while pend_valid is set.
    always_comb begin
        cap_word  = pend_src ? D1_data_out : D0_data_out;
        cap_class = {pend_src, cap_word[BW-1]};
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            last_grant <= 1'b1;
            pend_valid <= 1'b0;
            pend_src   <= 1'b0;
        end else begin
            if (D0_rd)      last_grant <= 1'b0;
            else if (D1_rd) last_grant <= 1'b1;
            pend_valid <= D0_rd | D1_rd;
            pend_src   <= D1_rd;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_data  <= '0;
            out_dest  <= 1'b0;
            out_valid <= 1'b0;
        end else if (pend_valid) begin
            out_data  <= cap_word;
            out_dest  <= pend_src;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (pend_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_class == 2'(i) && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end

    // Read-back handshake: a request sampled with req=1 and idle=1 on an edge yields
    // valid=1 for exactly the following cycle, with data = the counter value seen on
    // that edge (before any same-edge increment); otherwise valid=0 and data holds.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (req && idle) begin
            data  <= cnt[idx];
            valid <= 1'b1;
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_d_sink_counter.sv
// Directed bench for d_sink_counter: FIFO model on the inputs, scoreboard queues for the
// forwarded words and the count read-backs, checked by an independent monitor.
module tb_d_sink_counter;
  localparam int BW = 6;
  localparam int CW = 5;
  localparam int TW = 16;

  logic          clk;
  logic          reset_L;
  logic          pop_en;
  logic          D0_empty;
  logic          D1_empty;
  logic [BW-1:0] D0_data_out;
  logic [BW-1:0] D1_data_out;
  logic          idle;
  logic          req;
  logic [1:0]    idx;
  logic          D0_rd;
  logic          D1_rd;
  logic [BW-1:0] out_data;
  logic          out_dest;
  logic          out_valid;
  logic [CW-1:0] data;
  logic          valid;

  d_sink_counter #(.BW(BW), .CW(CW)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .pop_en      (pop_en),
    .D0_empty    (D0_empty),
    .D1_empty    (D1_empty),
    .D0_data_out (D0_data_out),
    .D1_data_out (D1_data_out),
    .idle        (idle),
    .req         (req),
    .idx         (idx),
    .D0_rd       (D0_rd),
    .D1_rd       (D1_rd),
    .out_data    (out_data),
    .out_dest    (out_dest),
    .out_valid   (out_valid),
    .data        (data),
    .valid       (valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  int checks = 0;
  int errors = 0;

  // scoreboard entries carry the cycle stamp at which the response is due
  logic [TW+1+BW-1:0] exp_out_q[$];
  logic [TW+CW-1:0]   exp_rd_q[$];
  logic [BW-1:0]      d0_q[$];
  logic [BW-1:0]      d1_q[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [TW+1+BW-1:0] eo;
    logic [TW+CW-1:0]   er;
    if (reset_L) begin
      if (out_valid) begin
        checks++;
        if (exp_out_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got dest=%0d word=%0h with nothing expected", out_dest, out_data);
        end else begin
          eo = exp_out_q.pop_front();
          if ({TW'(cyc_cnt), out_dest, out_data} !== eo) begin
            errors++;
            $display("FAIL out_word: got cyc=%0d dest=%0d word=%0h expected cyc=%0d dest=%0d word=%0h",
                     cyc_cnt, out_dest, out_data, eo[TW+BW:BW+1], eo[BW], eo[BW-1:0]);
          end
        end
      end
      if (valid) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got valid with data=%0d and nothing expected", data);
        end else begin
          er = exp_rd_q.pop_front();
          if ({TW'(cyc_cnt), data} !== er) begin
            errors++;
            $display("FAIL rd_data: got cyc=%0d data=%0d expected cyc=%0d data=%0d",
                     cyc_cnt, data, er[TW+CW-1:CW], er[CW-1:0]);
          end
        end
      end
    end
  end

  // driver: one clock cycle, entered and left on a falling edge
  task automatic cyc(input logic pe, input logic rq, input logic [1:0] ix, input logic id,
                     input logic [1:0] exp_rd, input logic [CW-1:0] exp_cnt);
    logic          took0, took1;
    logic [BW-1:0] w0, w1;
    pop_en   = pe;
    req      = rq;
    idx      = ix;
    idle     = id;
    D0_empty = (d0_q.size() == 0);
    D1_empty = (d1_q.size() == 0);
    #1;
    chk("rd_pattern", int'({D1_rd, D0_rd}), int'(exp_rd));
    if (exp_rd == 2'b01 && d0_q.size() > 0) exp_out_q.push_back({TW'(cyc_cnt + 2), 1'b0, d0_q[0]});
    if (exp_rd == 2'b10 && d1_q.size() > 0) exp_out_q.push_back({TW'(cyc_cnt + 2), 1'b1, d1_q[0]});
    if (rq && id) exp_rd_q.push_back({TW'(cyc_cnt + 1), exp_cnt});
    took0 = D0_rd && d0_q.size() > 0;
    took1 = D1_rd && d1_q.size() > 0;
    w0 = took0 ? d0_q.pop_front() : '0;
    w1 = took1 ? d1_q.pop_front() : '0;
    @(posedge clk);
    #1;
    D0_data_out = took0 ? w0 : BW'($urandom_range(0, 63));
    D1_data_out = took1 ? w1 : BW'($urandom_range(0, 63));
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset_L = 1'b0;
    #1;
    chk("rst_rd", int'({D1_rd, D0_rd}), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_dest", int'(out_dest), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_data", int'(data), 0);
    exp_out_q.delete();
    exp_rd_q.delete();
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    reset_L = 1'b0; pop_en = 1'b0; D0_empty = 1'b1; D1_empty = 1'b1;
    D0_data_out = '0; D1_data_out = '0; idle = 1'b0; req = 1'b0; idx = '0;
    @(negedge clk);
    do_reset();

    // mid-stream reset: a D0 pop is in flight, D0 still non-empty, pop_en high
    d0_q = '{6'h01, 6'h02};
    cyc(1, 0, 0, 0, 2'b01, 0);
    pop_en = 1'b1; D0_empty = 1'b0;
    do_reset();
    d1_q = '{6'h11};
    cyc(1, 0, 0, 0, 2'b01, 0);   // first tie after reset goes to D0
    cyc(1, 0, 0, 0, 2'b10, 0);
    cyc(0, 1, 0, 1, 2'b00, 1);   // discarded word 01 not counted
    cyc(0, 1, 2, 1, 2'b00, 1);

    // round-robin
    do_reset();
    d0_q = '{6'h01, 6'h02, 6'h03};
    d1_q = '{6'h11, 6'h12, 6'h13};
    cyc(1, 0, 0, 0, 2'b01, 0);
    cyc(1, 0, 0, 0, 2'b10, 0);
    cyc(1, 0, 0, 0, 2'b01, 0);
    cyc(1, 0, 0, 0, 2'b10, 0);
    cyc(1, 0, 0, 0, 2'b01, 0);
    cyc(1, 0, 0, 0, 2'b10, 0);
    cyc(1, 0, 0, 0, 2'b00, 0);
    cyc(0, 1, 0, 1, 2'b00, 3);
    cyc(0, 1, 2, 1, 2'b00, 3);

    // class counting
    do_reset();
    d0_q = '{6'h01, 6'h21, 6'h22};
    d1_q = '{6'h03};
    cyc(1, 0, 0, 0, 2'b01, 0);
    cyc(1, 0, 0, 0, 2'b10, 0);
    cyc(1, 0, 0, 0, 2'b01, 0);
    cyc(1, 0, 0, 0, 2'b01, 0);
    cyc(0, 0, 0, 0, 2'b00, 0);
    cyc(0, 1, 0, 1, 2'b00, 1);
    cyc(0, 1, 1, 1, 2'b00, 2);
    cyc(0, 1, 2, 1, 2'b00, 1);
    cyc(0, 1, 3, 1, 2'b00, 0);

    // saturation: 40 D1 words with vc_id=1
    do_reset();
    for (int i = 0; i < 40; i++) d1_q.push_back(BW'(6'h20 | (i % 32)));
    for (int i = 0; i < 40; i++) cyc(1, 0, 0, 0, 2'b10, 0);
    cyc(1, 0, 0, 0, 2'b00, 0);
    cyc(0, 1, 2, 1, 2'b00, 0);
    cyc(0, 1, 3, 1, 2'b00, 31);

    // idle gating: request with idle low is ignored and data holds
    cyc(0, 1, 2, 0, 2'b00, 0);
    chk("gate_valid", int'(valid), 0);
    chk("gate_data", int'(data), 31);
    cyc(0, 1, 2, 0, 2'b00, 0);
    chk("gate_data_hold", int'(data), 31);
    cyc(0, 1, 2, 1, 2'b00, 0);
    chk("gate_release_valid", int'(valid), 1);

    // pop_en drop after a D0 grant, read of the same class on the capture edge
    do_reset();
    d0_q = '{6'h24, 6'h25};
    cyc(1, 0, 0, 0, 2'b01, 0);
    cyc(0, 1, 1, 1, 2'b00, 0);
    cyc(0, 1, 1, 1, 2'b00, 1);
    cyc(0, 0, 0, 0, 2'b00, 0);
    cyc(0, 0, 0, 0, 2'b00, 0);

    chk("out_queue_drained", exp_out_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
